// File: rtl/fp_div.sv
// Sequential FP32 divider: restoring mantissa division, one quotient bit per clock,
// followed by a single normalise/exponent cycle. Fixed 26-edge latency for all operands.
module fp_div #(
   parameter logic [7:0] BIAS = 8'd127
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] out,
   output logic        done,
   output logic        busy,
   output logic        div_by_zero
);

   typedef enum logic [1:0] {StIdle, StCalc, StNorm} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q;
   logic [24:0] r_q;
   logic [23:0] d_q;
   logic [24:0] q_q;
   logic        sign_q, za_q, zb_q;
   logic [7:0]  a_exp_q, b_exp_q;
   logic [31:0] out_q;
   logic        done_q, dbz_q;

   logic        accept;
   logic        ge;
   logic [24:0] r_sub;
   logic [24:0] r_next;
   logic [9:0]  e_raw;
   logic signed [9:0] e;
   logic [22:0] mant;
   logic [31:0] result;
   logic        result_dbz;

   assign accept = (state_q == StIdle) && start;

   // Restoring step: subtract divisor when it fits, then shift the remainder left.
   always_comb begin
      ge     = (r_q >= {1'b0, d_q});
      r_sub  = ge ? (r_q - {1'b0, d_q}) : r_q;
      r_next = {r_sub[23:0], 1'b0};
   end

   // Normalise the quotient, form the biased exponent and select the final result.
   always_comb begin
      e_raw      = {2'b00, a_exp_q} - {2'b00, b_exp_q} + {2'b00, BIAS} - {9'd0, ~q_q[24]};
      e          = $signed(e_raw);
      mant       = q_q[24] ? q_q[23:1] : q_q[22:0];
      result_dbz = 1'b0;
      if (zb_q) begin
         result     = {sign_q, 8'hFF, 23'h0};
         result_dbz = 1'b1;
      end else if (za_q) begin
         result = {sign_q, 31'h0};
      end else if (e >= 10'sd255) begin
         result = {sign_q, 8'hFF, 23'h0};
      end else if (e <= 10'sd0) begin
         result = {sign_q, 31'h0};
      end else begin
         result = {sign_q, e[7:0], mant};
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StCalc;
         StCalc:  if (cnt_q == 5'd24) state_d = StNorm;
         StNorm:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Datapath: operand capture, iterations and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         r_q     <= '0;
         d_q     <= '0;
         q_q     <= '0;
         sign_q  <= 1'b0;
         za_q    <= 1'b0;
         zb_q    <= 1'b0;
         a_exp_q <= '0;
         b_exp_q <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            cnt_q   <= '0;
            r_q     <= {2'b01, a[22:0]};
            d_q     <= {1'b1, b[22:0]};
            q_q     <= '0;
            sign_q  <= a[31] ^ b[31];
            za_q    <= (a[30:23] == 8'h00);
            zb_q    <= (b[30:23] == 8'h00);
            a_exp_q <= a[30:23];
            b_exp_q <= b[30:23];
         end else if (state_q == StCalc) begin
            cnt_q <= cnt_q + 5'd1;
            r_q   <= r_next;
            q_q   <= {q_q[23:0], ge};
         end else if (state_q == StNorm) begin
            out_q  <= result;
            dbz_q  <= result_dbz;
            done_q <= 1'b1;
         end
      end
   end

   assign out         = out_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_fp_div.sv
// Directed testbench for fp_div: latency, results, special cases and control behaviour.
module tb_fp_div;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] out;
   logic        done;
   logic        busy;
   logic        div_by_zero;

   int total = 0;
   int bad   = 0;

   fp_div #(.BIAS(8'd127)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .a           (a),
      .b           (b),
      .out         (out),
      .done        (done),
      .busy        (busy),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Issue one operation and wait (bounded) for done. lat = edges from accept to done.
   task automatic do_op(input logic [31:0] ia, input logic [31:0] ib,
                        output int lat, output int busy_cnt,
                        output logic [31:0] res, output logic dbz);
      @(negedge clk);
      a = ia; b = ib; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 99; busy_cnt = busy ? 1 : 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (done) begin lat = n; break; end
         if (busy) busy_cnt++;
      end
      res = out; dbz = div_by_zero;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", out); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int lat, bc; logic [31:0] r; logic z;
      do_op(32'h40C00000, 32'h40000000, lat, bc, r, z);
      total++; if (lat !== 26) begin bad++; $display("FAIL basic_latency got=%0d exp=26", lat); end
      total++; if (r !== 32'h40400000) begin bad++; $display("FAIL basic_out got=%h exp=40400000", r); end
      total++; if (bc !== 26) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=26", bc); end
      total++; if (z !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b exp=0", z); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
      @(posedge clk); #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_one_cycle got=%b exp=0", done); end
   endtask

   task automatic test_vectors();
      logic [31:0] va [7];
      logic [31:0] vb [7];
      logic [31:0] vq [7];
      logic        vz [7];
      int lat, bc; logic [31:0] r; logic z;
      va[0] = 32'h3F800000; vb[0] = 32'h40400000; vq[0] = 32'h3EAAAAAA; vz[0] = 1'b0;
      va[1] = 32'hC0F00000; vb[1] = 32'h40200000; vq[1] = 32'hC0400000; vz[1] = 1'b0;
      va[2] = 32'hBF800000; vb[2] = 32'h00000000; vq[2] = 32'hFF800000; vz[2] = 1'b1;
      va[3] = 32'h00000000; vb[3] = 32'h00000000; vq[3] = 32'h7F800000; vz[3] = 1'b1;
      va[4] = 32'h00000000; vb[4] = 32'h40000000; vq[4] = 32'h00000000; vz[4] = 1'b0;
      va[5] = 32'h7F000000; vb[5] = 32'h3E800000; vq[5] = 32'h7F800000; vz[5] = 1'b0;
      va[6] = 32'h00800000; vb[6] = 32'h40000000; vq[6] = 32'h00000000; vz[6] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         do_op(va[i], vb[i], lat, bc, r, z);
         total++;
         if (lat !== 26) begin bad++; $display("FAIL vec%0d_latency got=%0d exp=26", i, lat); end
         total++;
         if (r !== vq[i]) begin bad++; $display("FAIL vec%0d_out got=%h exp=%h", i, r, vq[i]); end
         total++;
         if (z !== vz[i]) begin bad++; $display("FAIL vec%0d_dbz got=%b exp=%b", i, z, vz[i]); end
      end
   endtask

   task automatic test_ignore_start();
      int lat; int extra;
      @(negedge clk);
      a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      // Pulse start with new operands across E10, and leave operands changed.
      @(negedge clk);
      a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 99;
      for (int n = 11; n <= 40; n++) begin
         @(posedge clk); #1;
         if (done) begin lat = n; break; end
      end
      total++; if (lat !== 26) begin bad++; $display("FAIL ignore_latency got=%0d exp=26", lat); end
      total++; if (out !== 32'h40400000) begin bad++; $display("FAIL ignore_out got=%h exp=40400000", out); end
      extra = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk); #1;
         if (done || busy) extra++;
      end
      total++; if (extra !== 0) begin bad++; $display("FAIL ignore_no_queue got=%0d exp=0", extra); end
   endtask

   task automatic test_abort();
      int lat, bc, seen; logic [31:0] r; logic z;
      @(negedge clk);
      a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (12) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      total++; if (out !== 32'h0) begin bad++; $display("FAIL abort_out got=%h exp=0", out); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
      total++; if ({done, div_by_zero} !== 2'b00) begin bad++; $display("FAIL abort_flags got=%b exp=00", {done, div_by_zero}); end
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      seen = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk); #1;
         if (done || busy || out !== 32'h0) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
      do_op(32'h40C00000, 32'h40000000, lat, bc, r, z);
      total++; if (lat !== 26) begin bad++; $display("FAIL abort_rerun_latency got=%0d exp=26", lat); end
      total++; if (r !== 32'h40400000) begin bad++; $display("FAIL abort_rerun_out got=%h exp=40400000", r); end
   endtask

   task automatic test_back_to_back();
      int t1, t2, held;
      @(negedge clk);
      a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
      @(posedge clk); #1;
      t1 = -1; t2 = -1; held = 0;
      for (int n = 1; n <= 70; n++) begin
         @(posedge clk); #1;
         if (n == 30 && out !== 32'h40400000) held++;
         if (done) begin
            if (t1 < 0) t1 = n;
            else begin t2 = n; break; end
         end
      end
      start = 1'b0;
      a = '0; b = '0;
      total++; if (t1 !== 26) begin bad++; $display("FAIL b2b_first got=%0d exp=26", t1); end
      total++; if (t2 - t1 !== 27) begin bad++; $display("FAIL b2b_spacing got=%0d exp=27", t2 - t1); end
      total++; if (held !== 0) begin bad++; $display("FAIL b2b_out_held got=%0d exp=0", held); end
      total++; if (out !== 32'h40400000) begin bad++; $display("FAIL b2b_out got=%h exp=40400000", out); end
      repeat (30) @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_vectors();
      test_ignore_start();
      test_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_div.md
# fp_div

Sequential IEEE-754 single-precision divider (out = a / b) that complements the combinational `Mul` in the Maxnet arithmetic datapath. It is used wherever a neuron value must be scaled down by a runtime quantity, such as normalisation.
- It computes the mantissa quotient with a restoring divider that produces one quotient bit per clock.
- Normalisation and exponent adjustment happen in a final cycle.
- Latency is fixed for all operands, including special cases.
- Handshake is start/done, with a busy indication.

## Interface
Parameters:
- `BIAS`, default 8'd127: exponent bias.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled only while `busy`=0.
- `a`  input  32  dividend (FP32); captured on the accepting edge.
- `b`  input  32  divisor (FP32); captured on the accepting edge.
- `out`  output  32  quotient; held from `done` until the next accepted start.
- `done`  output  1  one-cycle pulse; `out` is valid in this cycle.
- `busy`  output  1  high while an operation is in flight.
- `div_by_zero`  output  1  registered alongside `out`; 1 when `b` was zero.

## Operation
- Operand capture on accept:
  - sign = a[31]^b[31];
  - dividend register = {1,a[22:0]}; divisor register = {1,b[22:0]};
  - zero flags: za = (a[30:23]==0), zb = (b[30:23]==0).
- Denormal handling: exponent field 0 means zero (denormals are flushed).
- Exponent 0xFF: no NaN/Inf decoding; such inputs are treated as ordinary values.
- State machine:
  - IDLE: on start, capture operands, clear the 5-bit iteration counter, go to CALC.
  - CALC: 25 iterations, one per clock.
    - If r ≥ d: q = {q,1}, r = (r−d)<<1.
    - Else: q = {q,0}, r = r<<1.
    - r is 25 bits wide.
    - After the 25th iteration, go to NORM.
  - NORM: register the result, pulse `done`, go to IDLE.
- Quotient q[24:0] represents a value in (0.5, 2).
- Normalisation and exponent arithmetic (signed 10-bit):
  - If q[24]=1: mantissa = q[23:1], e = a_exp − b_exp + BIAS.
  - Else: mantissa = q[22:0], e = a_exp − b_exp + BIAS − 1.
- Rounding: truncation (round toward zero); no sticky or guard rounding.
- Result selection, in priority order:
  1. zb: {sign, 8'hFF, 23'h0} with `div_by_zero`=1. This includes 0/0.
  2. za: {sign, 31'h0}.
  3. e ≥ 255: {sign, 8'hFF, 23'h0} (overflow to ±Inf; `div_by_zero`=0).
  4. e ≤ 0: {sign, 31'h0} (underflow to ±0).
  5. Otherwise: {sign, e[7:0], mantissa}.
- Special cases run the full CALC sequence, so latency is constant.

## Timing
- Reset (asynchronous, any time, including mid-operation):
  - state = IDLE;
  - `out`=0, `done`=0, `busy`=0, `div_by_zero`=0;
  - the in-flight operation is discarded.
  - After `rst_n` rises, the first edge may accept `start`.
- Accepting edge E0 (start=1 while IDLE):
  - `busy`=1 from E0.
  - Edges E1..E25 perform the iterations.
  - E26 writes `out`/`div_by_zero`, sets `done`=1 and `busy`=0.
- `done` is high for exactly one cycle, between E26 and E27.
- Latency: result is visible 26 edges after acceptance.
- Throughput: one operation per 27 cycles. `start` held high during the `done` cycle is accepted at E27.
- Start while busy: `start`=1 between E0 and E26 is ignored. Operands are not re-captured and no queuing occurs.
- Changing `a`/`b` after E0 has no effect on the current operation.
- `out` is stable outside E26 writes; it is not cleared on accept.

## Test plan
- 0x40C00000 / 0x40000000 (6.0/2.0): `done` exactly 26 edges after accept, `out`=0x40400000, `busy` high for 26 cycles, `div_by_zero`=0.
- 0x3F800000 / 0x40400000 (1/3): `out`=0x3EAAAAAA (truncated).
- 0xC0F00000 / 0x40200000 (−7.5/2.5): `out`=0xC0400000.
- Divide by zero:
  - 0xBF800000 / 0x00000000: `out`=0xFF800000, `div_by_zero`=1.
  - 0x00000000 / 0x00000000: `out`=0x7F800000, `div_by_zero`=1.
  - 0x00000000 / 0x40000000: `out`=0x00000000, `div_by_zero`=0.
- Overflow and underflow:
  - 0x7F000000 / 0x3E800000: `out`=0x7F800000, `div_by_zero`=0.
  - 0x00800000 / 0x40000000: `out`=0x00000000.
- Control behaviour:
  - Pulse `start` with new operands at E10 of an operation: ignored, first result unchanged.
  - Assert `rst_n`=0 at E12, then issue 6.0/2.0: no `done` from the aborted operation, all outputs 0 during reset, then 0x40400000 after 26 edges.
  - Back-to-back `start` held high: second `done` 27 edges after the first.
